// File: rtl/gtech_ld_bank.sv
// rtl/gtech_ld_bank.sv - multi-channel synchronous gated-latch bank with shadow register and change flags
//
// Purpose:
//   NCH independent WIDTH-bit holding channels. Each channel has its own
//   active-low gate and active-low clear. MODE selects level capture (every
//   gated cycle) or edge capture (first gated cycle after the gate was high).
//   A shadow bank takes a snapshot of the live bank on LOAD. A sticky change
//   flag per channel records any change of the live value.
//
// Ports:
//   CP       clock, rising edge
//   CD       synchronous active-low reset
//   D        channel data, channel i = D[i*WIDTH +: WIDTH]
//   GN       per-channel gate, active-low
//   CDN      per-channel synchronous clear, active-low
//   LOAD     copy live bank (pre-update value) into shadow bank
//   CHG_CLR  clear all change flags (a simultaneous set wins)
//   Q        live held values
//   QS       shadow values
//   CHG      sticky per-channel change flags

module gtech_ld_bank #(
    parameter int               WIDTH   = 8,
    parameter int               NCH     = 4,
    parameter int               MODE    = 0,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                   CP,
    input  logic                   CD,
    input  logic [NCH*WIDTH-1:0]   D,
    input  logic [NCH-1:0]         GN,
    input  logic [NCH-1:0]         CDN,
    input  logic                   LOAD,
    input  logic                   CHG_CLR,
    output logic [NCH*WIDTH-1:0]   Q,
    output logic [NCH*WIDTH-1:0]   QS,
    output logic [NCH-1:0]         CHG
);

    logic [NCH*WIDTH-1:0] q_r;
    logic [NCH*WIDTH-1:0] qs_r;
    logic [NCH-1:0]       chg_r;
    logic [NCH-1:0]       gn_hist;

    logic [NCH-1:0]       cap;
    logic [NCH*WIDTH-1:0] q_nxt;
    logic [NCH-1:0]       chg_set;

    // Edge mode only captures on a high-to-low gate transition; the history
    // resets to all ones so the first low cycle after reset is a transition.
    assign cap = (MODE != 0) ? (gn_hist & ~GN) : ~GN;

    always_comb begin
        q_nxt   = q_r;
        chg_set = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!CDN[i]) begin
                q_nxt[i*WIDTH +: WIDTH] = RST_VAL;
            end else if (cap[i]) begin
                q_nxt[i*WIDTH +: WIDTH] = D[i*WIDTH +: WIDTH];
            end
            chg_set[i] = (q_nxt[i*WIDTH +: WIDTH] != q_r[i*WIDTH +: WIDTH]);
        end
    end

    always_ff @(posedge CP) begin
        if (!CD) begin
            q_r     <= {NCH{RST_VAL}};
            qs_r    <= {NCH{RST_VAL}};
            chg_r   <= '0;
            gn_hist <= '1;
        end else begin
            q_r     <= q_nxt;
            gn_hist <= GN;
            // Shadow takes the value held before this edge, so a capture in
            // the same cycle only reaches QS on a later LOAD.
            if (LOAD) begin
                qs_r <= q_r;
            end
            chg_r <= chg_set | (chg_r & ~{NCH{CHG_CLR}});
        end
    end

    assign Q   = q_r;
    assign QS  = qs_r;
    assign CHG = chg_r;

endmodule

// File: doc/gtech_ld_bank.md
Name: gtech_ld_bank

Overview:
- Clocked, parametrised successor to the single-bit GTECH gated latch with active-low gate and active-low clear.
- Provides NCH channels of WIDTH bits. Each channel has its own active-low gate and active-low clear.
- Mode is selectable: level (transparent-equivalent) or edge (capture once per gate assertion).
- Adds a shadow/commit register and sticky per-channel change flags. Used wherever latch-style holding is needed in a fully synchronous flow.

Parameters:
- WIDTH, 8: data bits per channel (>=1).
- NCH, 4: number of channels (>=1).
- MODE, 0: 0 = level (capture every cycle GN[i]=0); 1 = edge (capture only on the first cycle of GN[i]=0 after GN[i]=1).
- RST_VAL, 0: WIDTH-bit value loaded into every Q/QS channel on reset or clear.

Ports:
- CP  input  1  clock; all state updates on rising edge.
- CD  input  1  reset, synchronous, active-low; sampled on CP rising edge.
- D  input  NCH*WIDTH  channel data; channel i = D[i*WIDTH +: WIDTH].
- GN  input  NCH  per-channel gate, active-low.
- CDN  input  NCH  per-channel clear, active-low, synchronous.
- LOAD  input  1  commit strobe; copies the live bank into the shadow bank.
- CHG_CLR  input  1  clears all CHG flags.
- Q  output  NCH*WIDTH  live held values (registered).
- QS  output  NCH*WIDTH  shadow values (registered).
- CHG  output  NCH  sticky flag: channel Q value changed since last clear.

Behaviour:
- Reset (CD=0 at edge):
  - Q and QS channels = RST_VAL; CHG = 0; internal GN history = all 1s.
  - Overrides every other input. Reset mid-operation discards the pending capture and LOAD in that cycle.
- Priority per channel i, per edge: CD > CDN[i] > capture. Per-channel clear:
  - CDN[i]=0 sets Q[i] = RST_VAL. QS[i] is untouched.
  - The GN history bit for channel i is still updated from GN[i].
- Capture, MODE=0: GN[i]=0 and CDN[i]=1 gives Q[i] <= D[i] at that edge. GN[i]=1 holds.
  - Latency: D sampled at edge n appears on Q at edge n, i.e. one cycle after presentation.
- Capture, MODE=1:
  - Capture when GN_hist[i]=1 and GN[i]=0. Otherwise hold, including while GN[i] stays low.
  - GN_hist[i] <= GN[i] every non-reset edge.
  - The first low cycle after reset counts as a falling edge.
- Shadow:
  - LOAD=1 gives QS <= Q as registered before this edge, i.e. the pre-update value, all channels at once.
  - A capture in the same cycle is not included; it reaches QS only on a later LOAD.
- Change flags:
  - CHG[i] <= 1 when the next Q[i] differs from the current Q[i], from either capture or CDN clear.
  - CHG_CLR=1 clears all flags. If a set and CHG_CLR coincide, set wins.
- No combinational path from any input to any output; all outputs are registered.
- Channels are fully independent except for the shared CD, LOAD and CHG_CLR.

Test Plan:
- Reset, default params:
  - Stimulus: drive D=all 1s, GN=0, CD=0 for 2 edges.
  - Required: Q=0, QS=0, CHG=0.
  - Then CD=1, one edge: Q=32'hFFFFFFFF, CHG=4'hF.
- Level mode hold:
  - Stimulus: ch0 GN=0 with D=8'h5A for one edge; then GN=1 and D=8'hA5 for 3 edges.
  - Required: Q[7:0] stays 8'h5A; other channels unchanged.
- Edge mode (MODE=1):
  - Stimulus: hold GN[1]=0 for 4 edges while D[15:8] steps 01,02,03,04.
  - Required: Q[15:8]=8'h01 throughout.
  - Then GN[1]=1 for 1 edge, GN[1]=0 with D=8'h09: Q[15:8]=8'h09.
- Priority:
  - Stimulus: ch2 GN=0, D=8'h33 and CDN[2]=0 on the same edge.
  - Required: Q[23:16]=RST_VAL (0); CHG[2] is set only if the prior value was nonzero.
  - Then CD=0 together with LOAD=1: Q=0, QS=0, CHG=0.
- Shadow timing:
  - Stimulus: Q[7:0]=8'h11; then one edge with GN[0]=0, D=8'h22, LOAD=1.
  - Required: QS[7:0]=8'h11, Q[7:0]=8'h22.
  - Next edge with LOAD=1: QS[7:0]=8'h22.
- Change flag collision:
  - Stimulus: CHG_CLR=1 in the same edge as ch3 capturing a new value.
  - Required: CHG=4'b1000.
  - Next edge with CHG_CLR=1 and no changes: CHG=0.
